// File: rtl/obi_sbr_pkg.sv
// Shared types and helpers for the OBI SRAM subordinate and its response FIFO.
package obi_sbr_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH       = DEF_DATA_WIDTH / 8;

    // rdata is sized for the widest legal bus; narrower builds zero the upper bits.
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } obi_rsp_t;

    function automatic logic [63:0] word_index(input logic [63:0] offset,
                                               input int unsigned lsb_bits,
                                               input int unsigned idx_bits);
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return (offset >> lsb_bits) & mask;
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order response FIFO holding obi_rsp_t entries between the A and R channels.
module obi_rsp_fifo
    import obi_sbr_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           push,
    input  logic                           pop,
    input  obi_rsp_t                       wdata,
    output obi_rsp_t                       rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(RSP_DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    obi_rsp_t        storage [RSP_DEPTH];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] cnt;
    logic            push_en;
    logic            pop_en;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (cnt == CntW'(RSP_DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rdata   = storage[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_en && !pop_en) begin
                cnt <= cnt + CntW'(1);
            end else if (pop_en && !push_en) begin
                cnt <= cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            storage[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/obi_sram_subordinate.sv
// OBI subordinate backed by a word-addressed SRAM with buffered in-order responses.
// Define OBI_SBR_RANGE_ERR_EN to flag out-of-range accesses with err instead of wrapping.
module obi_sram_subordinate
    import obi_sbr_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);

    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam int unsigned LsbW = $clog2(BeW);
    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] offset;
    logic [IdxW-1:0]       idx;
    logic                  out_of_range;
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       unused_count;
    logic                  unused_head_bits;
    obi_rsp_t              push_rsp;
    obi_rsp_t              head_rsp;

    assign offset = obi_addr_i - BASE_ADDR;
    assign idx    = IdxW'(word_index(64'(offset), LsbW, IdxW));

`ifdef OBI_SBR_RANGE_ERR_EN
    assign out_of_range = (64'(offset) >= 64'(MEM_DEPTH) * 64'(BeW));
`else
    assign out_of_range = 1'b0;
`endif

    assign obi_rvalid_o = !fifo_empty;
    assign pop          = obi_rvalid_o && obi_rready_i;
    assign obi_gnt_o    = obi_req_i && reset_ni && (!fifo_full || pop);
    assign accept       = obi_req_i && obi_gnt_o;

    always_ff @(posedge clk_i) begin
        if (accept && obi_we_i && !out_of_range) begin
            for (int k = 0; k < BeW; k++) begin
                if (obi_be_i[k]) begin
                    mem[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write; a later read sees the new word.
    always_comb begin
        push_rsp = '0;
        if (out_of_range) begin
            push_rsp.err = 1'b1;
        end else if (!obi_we_i) begin
            push_rsp.rdata[DATA_WIDTH-1:0] = mem[idx];
        end
    end

    obi_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (accept),
        .pop      (pop),
        .wdata    (push_rsp),
        .rdata    (head_rsp),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (unused_count)
    );

    assign obi_rdata_o      = obi_rvalid_o ? head_rsp.rdata[DATA_WIDTH-1:0] : '0;
    assign obi_err_o        = obi_rvalid_o && head_rsp.err;
    assign unused_head_bits = ^head_rsp.rdata;

endmodule

// File: tb/tb_obi_sram_subordinate.sv
// Directed scoreboard bench for obi_sram_subordinate (32-bit data, 256 words, 2-entry FIFO).
module tb_obi_sram_subordinate;

    localparam int unsigned RSP_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    int          checks   = 0;
    int          failures = 0;
    int          accepts  = 0;

    obi_sram_subordinate #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (256),
        .BASE_ADDR  (32'h0),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model the accept of the current request: memory update and expected response.
    task automatic model_accept();
        exp_t        e;
        logic [7:0]  idx;
        logic        oor;
        idx = addr[9:2];
`ifdef OBI_SBR_RANGE_ERR_EN
        oor = (addr >= 32'h400);
`else
        oor = 1'b0;
`endif
        e.rdata = 32'h0;
        e.err   = oor;
        if (!oor) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) model_mem[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end else begin
                e.rdata = model_mem[idx];
            end
        end
        sb.push_back(e);
        accepts++;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic tick();
        logic exp_gnt;
        exp_t e;
        #1;
        exp_gnt = req && rst_n &&
                  ((sb.size() < RSP_DEPTH) || ((sb.size() != 0) && rready));
        chk("gnt", {63'h0, gnt}, {63'h0, exp_gnt});
        chk("rvalid", {63'h0, rvalid}, {63'h0, (sb.size() != 0)});
        if (sb.size() == 0) begin
            chk("idle_rsp", {31'h0, err, rdata}, 64'h0);
        end else if (rready) begin
            e = sb.pop_front();
            chk("rdata", {32'h0, rdata}, {32'h0, e.rdata});
            chk("err", {63'h0, err}, {63'h0, e.err});
        end
        if (exp_gnt) model_accept();
        @(posedge clk);
        if (!rst_n) sb.delete();
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
        req   = 1'b1;
        addr  = a;
        we    = w;
        be    = b;
        wdata = d;
    endtask

    task automatic idle();
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic drain();
        rready = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        int start;
        rst_n  = 1'b0;
        rready = 1'b1;
        addr   = 32'h0;
        idle();
        @(posedge clk);
        #1;
        req = 1'b1;
        tick();
        tick();
        chk("rst_rvalid", {63'h0, rvalid}, 64'h0);
        chk("rst_rdata", {32'h0, rdata}, 64'h0);
        req   = 1'b0;
        rst_n = 1'b1;
        tick();

        // Write then read.
        drive(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        tick();
        drive(32'h10, 1'b0, 4'h0, 32'h0);
        tick();
        idle();
        tick();

        // Byte enables.
        drive(32'h20, 1'b1, 4'hF, 32'h11223344);
        tick();
        drive(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        tick();
        drive(32'h20, 1'b0, 4'h0, 32'h0);
        tick();
        drain();

        // Backpressure: third request must wait for the first pop.
        rready = 1'b0;
        drive(32'h10, 1'b0, 4'h0, 32'h0);
        tick();
        drive(32'h20, 1'b0, 4'h0, 32'h0);
        tick();
        drive(32'h00, 1'b1, 4'hF, 32'hCAFEF00D);
        tick();
        tick();
        rready = 1'b1;
        tick();
        drain();

        // Wrap / range: 0x400 maps to word 0 or is flagged out of range.
        drive(32'h400, 1'b0, 4'h0, 32'h0);
        tick();
        drive(32'h400, 1'b1, 4'hF, 32'h12345678);
        tick();
        drive(32'h000, 1'b0, 4'h0, 32'h0);
        tick();
        drain();

        // Reset with two responses pending.
        rready = 1'b0;
        drive(32'h10, 1'b0, 4'h0, 32'h0);
        tick();
        drive(32'h20, 1'b0, 4'h0, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_rvalid", {63'h0, rvalid}, 64'h0);
        rst_n  = 1'b1;
        rready = 1'b1;
        drive(32'h10, 1'b0, 4'h0, 32'h0);
        tick();
        drain();

        // Streaming: eight writes then eight reads, one per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + 32'(i * 4), 1'b1, 4'hF, 32'hA5000000 + 32'(i * 32'h01010101));
            tick();
        end
        start = accepts;
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
            tick();
        end
        chk("stream_grants", 64'(accepts - start), 64'd8);
        drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
